lzc_pipelined: RTL and testbench

- Parametrised, pipelined successor to the combinational leading-zero counter tree.
- Counts leading zeros, or trailing zeros, selectable per transaction, on a WIDTH-bit operand.
- Register stages are placed inside the reduction tree so the count meets timing at wide WIDTH.
- Valid/ready handshake on both sides; a tag sideband rides along with each operand. Intended for normaliser and priority-select paths.

---
 rtl/lzc_pipelined.sv | 172 +++++++++++++++++
 tb/tb_lzc_pipelined.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_pipelined.sv
// lzc_pipelined
//   Pipelined leading/trailing zero counter for normaliser and priority-select
//   paths. A binary reduction tree of COUNT levels finds the first set bit;
//   register stages are spread evenly through the tree so wide operands still
//   close timing. Trailing-zero mode bit-reverses the operand in front of the
//   same tree.
//
// Parameters
//   WIDTH       operand width, power of two, >= 2
//   COUNT       $clog2(WIDTH), derived, do not override
//   PIPE_STAGES number of register stages, 0..COUNT (0 = combinational)
//   TAG_W       sideband tag width, >= 1
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake
//   in_data, in_mode, in_tag operand, 0 = leading / 1 = trailing, sideband tag
//   out_valid/out_ready      result handshake
//   out_count                zero count 0..WIDTH
//   out_zero                 operand was all zeros
//   out_tag                  tag travelling with this result
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. valid never depends on ready. The whole pipe moves on one enable,
// advance = ~out_valid | out_ready, which is also in_ready; empty slots shift
// like full ones, so a stalled result holds its outputs stable and nothing is
// accepted until downstream takes it.
module lzc_pipelined #(
  parameter int WIDTH       = 16,
  parameter int COUNT       = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COUNT:0]   out_count,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Elaboration guards on the parameter space.
  if (!((WIDTH >= 2) && ((WIDTH & (WIDTH - 1)) == 0))) begin : g_bad_width
    $fatal(1, "lzc_pipelined: WIDTH must be a power of two >= 2");
  end
  if (COUNT != $clog2(WIDTH)) begin : g_bad_count
    $fatal(1, "lzc_pipelined: COUNT must equal $clog2(WIDTH)");
  end
  if ((PIPE_STAGES < 0) || (PIPE_STAGES > COUNT)) begin : g_bad_stages
    $fatal(1, "lzc_pipelined: PIPE_STAGES must be in 0..COUNT");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "lzc_pipelined: TAG_W must be >= 1");
  end

  // A register follows tree level round(COUNT*s/PIPE_STAGES) for s = 1..PIPE_STAGES.
  // Rounding is half-up in integer form; since PIPE_STAGES <= COUNT the
  // chosen levels are always distinct and the last one is level COUNT.
  function automatic bit is_stage(input int level);
    bit hit;
    hit = 1'b0;
    for (int s = 1; s <= PIPE_STAGES; s++) begin
      if (((2 * COUNT * s) + PIPE_STAGES) / (2 * PIPE_STAGES) == level) hit = 1'b1;
    end
    return hit;
  endfunction

  logic advance;

  if (PIPE_STAGES == 0) begin : g_comb_hs
    assign advance = out_ready;
  end else begin : g_pipe_hs
    assign advance = ~out_valid | out_ready;
  end
  assign in_ready = advance;

  // Trailing-zero mode: reverse the operand so the tree always scans from the top.
  logic [WIDTH-1:0] tree_in;
  always_comb begin
    tree_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tree_in[i] = in_mode ? in_data[WIDTH-1-i] : in_data[i];
    end
  end

  // Level lvl holds WIDTH>>lvl nodes. Each node covers 2**lvl operand bits and
  // carries z (all bits zero) plus an lvl-bit leading-zero count that is only
  // meaningful when z = 0. Node i's children at the level below are 2i (low
  // half) and 2i+1 (high half).
  for (genvar lvl = 1; lvl <= COUNT; lvl++) begin : g_lvl
    localparam int N = WIDTH >> lvl;

    logic [N-1:0]     z_c;
    logic [N-1:0]     z_o;
    logic [N*lvl-1:0] c_c;
    logic [N*lvl-1:0] c_o;
    logic             v_i;
    logic             v_o;
    logic [TAG_W-1:0] t_i;
    logic [TAG_W-1:0] t_o;

    if (lvl == 1) begin : g_leaf
      assign v_i = in_valid;
      assign t_i = in_tag;
      always_comb begin
        z_c = '0;
        c_c = '0;
        for (int i = 0; i < N; i++) begin
          z_c[i] = ~(tree_in[2*i+1] | tree_in[2*i]);
          c_c[i] = ~tree_in[2*i+1];
        end
      end
    end else begin : g_node
      logic [2*N-1:0]         pz;
      logic [2*N*(lvl-1)-1:0] pc;
      assign pz  = g_lvl[lvl-1].z_o;
      assign pc  = g_lvl[lvl-1].c_o;
      assign v_i = g_lvl[lvl-1].v_o;
      assign t_i = g_lvl[lvl-1].t_o;
      // If the high half is all zero, the count is half-width plus the low
      // half's count; otherwise it is the high half's count.
      always_comb begin
        z_c = '0;
        c_c = '0;
        for (int i = 0; i < N; i++) begin
          z_c[i] = pz[2*i+1] & pz[2*i];
          c_c[i*lvl +: lvl] = pz[2*i+1] ? {1'b1, pc[(2*i)*(lvl-1) +: lvl-1]}
                                        : {1'b0, pc[(2*i+1)*(lvl-1) +: lvl-1]};
        end
      end
    end

    if (is_stage(lvl)) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_o <= 1'b0;
          z_o <= '0;
          c_o <= '0;
          t_o <= '0;
        end else if (advance) begin
          v_o <= v_i;
          z_o <= z_c;
          c_o <= c_c;
          t_o <= t_i;
        end
      end
    end else begin : g_pass
      assign v_o = v_i;
      assign z_o = z_c;
      assign c_o = c_c;
      assign t_o = t_i;
    end
  end

  logic             root_z;
  logic [COUNT-1:0] root_c;

  assign root_z    = g_lvl[COUNT].z_o;
  assign root_c    = g_lvl[COUNT].c_o;
  assign out_valid = g_lvl[COUNT].v_o;
  assign out_tag   = g_lvl[COUNT].t_o;
  assign out_zero  = root_z;
  // All-zero operand reports WIDTH, i.e. only the MSB of out_count set.
  assign out_count = root_z ? (COUNT+1)'(WIDTH) : {1'b0, root_c};

endmodule

// File: tb/tb_lzc_pipelined.sv
// tb_lzc_pipelined
//   Self-checking bench for lzc_pipelined. One WIDTH=16 / PIPE_STAGES=2
//   instance takes directed sequences (reset, leading, trailing, backpressure,
//   mid-flight reset); a swept set of instances takes random traffic. Every
//   instance has a negedge compare process against a queue of results from a
//   bit-scanning reference model.
module tb_lzc_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int sweeps_done = 0;

  localparam int NCFG = 8;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan from the MSB (mode 0) or LSB (mode 1) until the first 1.
  function automatic int ref_count(input logic [63:0] d, input int w, input bit mode);
    for (int i = 0; i < w; i++) begin
      if (d[mode ? i : (w - 1 - i)]) return i;
    end
    return w;
  endfunction

  function automatic int cfg_w(input int g);
    case (g)
      0, 1:    return 2;
      2, 3, 4: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_p(input int g);
    case (g)
      0, 2, 5: return 0;
      1, 3, 6: return 1;
      4:       return 3;
      default: return 6;
    endcase
  endfunction

  always @(negedge clk) ncyc++;

  // ---------------- main instance: WIDTH=16, PIPE_STAGES=2 ----------------
  logic        m_rst, m_in_valid, m_in_ready, m_in_mode, m_out_valid, m_out_ready, m_out_zero;
  logic [15:0] m_in_data;
  logic [3:0]  m_in_tag, m_out_tag;
  logic [4:0]  m_out_count;

  lzc_pipelined #(.WIDTH(16), .PIPE_STAGES(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(m_rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_mode(m_in_mode), .in_tag(m_in_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_count(m_out_count),
    .out_zero(m_out_zero), .out_tag(m_out_tag)
  );

  logic [9:0] exp_q[$];   // {count, zero, tag}
  int         acc_log[$];
  int         obs_cnt[$];
  int         obs_zero[$];
  int         obs_tag[$];
  int         obs_cyc[$];
  bit         m_stall = 1'b0;
  logic [9:0] m_held;

  always @(negedge clk) begin
    logic [9:0] got;
    int c;
    got = {m_out_count, m_out_zero, m_out_tag};
    if (!m_rst) begin
      check("m_in_ready_rule", m_in_ready, !m_out_valid || m_out_ready);
      if (m_stall) check("m_hold_while_stalled", got, m_held);
      if (m_in_valid && m_in_ready) begin
        c = ref_count(64'(m_in_data), 16, m_in_mode);
        exp_q.push_back({5'(c), 1'(c == 16), m_in_tag});
        acc_log.push_back(ncyc);
      end
      if (m_out_valid && m_out_ready) begin
        check("m_result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("m_result", got, exp_q.pop_front());
        obs_cnt.push_back(int'(m_out_count));
        obs_zero.push_back(int'(m_out_zero));
        obs_tag.push_back(int'(m_out_tag));
        obs_cyc.push_back(ncyc);
      end
      m_stall = m_out_valid && !m_out_ready;
      m_held  = got;
    end
  end

  task automatic clear_obs();
    acc_log.delete(); obs_cnt.delete(); obs_zero.delete(); obs_tag.delete(); obs_cyc.delete();
  endtask

  // Present one operand (caller is just after a rising edge) and return just
  // after the edge that accepted it.
  task automatic send(input logic [15:0] d, input logic mode, input logic [3:0] tag);
    int n;
    n = 0;
    m_in_valid = 1'b1; m_in_data = d; m_in_mode = mode; m_in_tag = tag;
    @(negedge clk);
    while (!m_in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("m_send_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    m_in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_list(input string name, input int exp_cnt[8], input int exp_zero[8], input int n);
    check({name, "_count_n"}, obs_cnt.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_count%0d", name, i), obs_cnt[i], exp_cnt[i]);
      check($sformatf("%s_zero%0d", name, i), obs_zero[i], exp_zero[i]);
    end
  endtask

  // ---------------- swept instances with random traffic ----------------
  int first_count_g0;
  int first_valid_g0;

  for (genvar g = 0; g < NCFG; g++) begin : g_sweep
    localparam int W  = cfg_w(g);
    localparam int P  = cfg_p(g);
    localparam int CW = $clog2(W);

    logic          s_rst, s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_zero;
    logic [W-1:0]  s_in_data;
    logic [3:0]    s_in_tag, s_out_tag;
    logic [CW:0]   s_out_count;
    logic [CW+5:0] s_q[$];
    bit            s_stall = 1'b0;
    logic [CW+5:0] s_held;
    int            first_count;
    int            first_valid;

    lzc_pipelined #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(4)) u_dut (
      .clk(clk), .rst(s_rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .in_mode(s_in_mode), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_count(s_out_count),
      .out_zero(s_out_zero), .out_tag(s_out_tag)
    );

    always @(negedge clk) begin
      logic [CW+5:0] got;
      int c;
      got = {s_out_count, s_out_zero, s_out_tag};
      if (!s_rst) begin
        check($sformatf("w%0d_p%0d_in_ready", W, P), s_in_ready,
              (P == 0) ? s_out_ready : (!s_out_valid || s_out_ready));
        if (P > 0 && s_stall) check($sformatf("w%0d_p%0d_hold", W, P), got, s_held);
        if (s_in_valid && s_in_ready) begin
          c = ref_count(64'(s_in_data), W, s_in_mode);
          s_q.push_back({(CW+1)'(c), 1'(c == W), s_in_tag});
        end
        if (s_out_valid && s_out_ready) begin
          check($sformatf("w%0d_p%0d_expected", W, P), s_q.size() != 0, 1);
          if (s_q.size() != 0) check($sformatf("w%0d_p%0d_result", W, P), got, s_q.pop_front());
        end
        s_stall = s_out_valid && !s_out_ready;
        s_held  = got;
      end
    end

    initial begin
      logic [63:0] r;
      int k;
      s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_in_data = '0; s_in_mode = 1'b0; s_in_tag = '0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      // Operand ...0001, leading-zero mode, sampled in the same cycle it is presented.
      s_in_valid = 1'b1; s_in_data = W'(1); s_in_mode = 1'b0; s_in_tag = 4'hA; s_out_ready = 1'b1;
      #1;
      first_count = int'(s_out_count);
      first_valid = int'(s_out_valid);
      for (int t = 0; t < 400; t++) begin
        @(posedge clk); #1;
        s_in_valid  = ($urandom_range(0, 3) != 0);
        s_out_ready = ($urandom_range(0, 2) != 0);
        s_in_mode   = 1'($urandom_range(0, 1));
        s_in_tag    = 4'($urandom);
        r = {$urandom(), $urandom()};
        k = $urandom_range(0, W);
        if (s_in_mode) s_in_data = W'(r << k);
        else           s_in_data = W'((r >> (64 - W)) >> k);
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      repeat (P + 4) @(posedge clk);
      #1 check($sformatf("w%0d_p%0d_drained", W, P), s_q.size(), 0);
      sweeps_done++;
    end
  end

  assign first_count_g0 = g_sweep[0].first_count;
  assign first_valid_g0 = g_sweep[0].first_valid;

  // ---------------- directed sequence on the main instance ----------------
  initial begin
    int n;
    int exp_cnt[8];
    int exp_zero[8];

    m_rst = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b1;
    m_in_data = '0; m_in_mode = 1'b0; m_in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_count", m_out_count, 0);
    check("rst_out_tag", m_out_tag, 0);
    m_rst = 1'b0;
    #1;
    check("post_rst_in_ready", m_in_ready, 1);
    check("post_rst_out_zero", m_out_zero, 0);

    // Leading zeros, back to back.
    clear_obs();
    send(16'h8000, 1'b0, 4'd1);
    send(16'h0001, 1'b0, 4'd2);
    send(16'h0000, 1'b0, 4'd3);
    send(16'h00F0, 1'b0, 4'd4);
    idle(6);
    exp_cnt  = '{0, 15, 16, 8, 0, 0, 0, 0};
    exp_zero = '{0, 0, 1, 0, 0, 0, 0, 0};
    check_list("lzc", exp_cnt, exp_zero, 4);
    for (int i = 0; i < 4; i++) check($sformatf("lzc_tag%0d", i), obs_tag[i], i + 1);
    check("lzc_latency", obs_cyc[0] - acc_log[0], 2);
    check("lzc_throughput", obs_cyc[3] - obs_cyc[0], 3);

    // Trailing zeros, then a leading/trailing interleave.
    clear_obs();
    send(16'h8000, 1'b1, 4'd5);
    send(16'h0001, 1'b1, 4'd6);
    send(16'h0000, 1'b1, 4'd7);
    send(16'h0A00, 1'b1, 4'd8);
    send(16'h0F00, 1'b0, 4'd9);
    send(16'h0F00, 1'b1, 4'd10);
    send(16'h0010, 1'b0, 4'd11);
    send(16'h0010, 1'b1, 4'd12);
    idle(6);
    exp_cnt  = '{15, 0, 16, 9, 4, 8, 11, 4};
    exp_zero = '{0, 0, 1, 0, 0, 0, 0, 0};
    check_list("tzc", exp_cnt, exp_zero, 8);

    // Backpressure: out_ready low for cycles 3..5, then toggling.
    clear_obs();
    fork
      begin
        for (int t = 0; t < 20; t++) send(16'($urandom), 1'($urandom_range(0, 1)), 4'(t));
        m_in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          m_out_ready = (k >= 3 && k <= 5) ? 1'b0 : ((k > 5) ? 1'(k % 2) : 1'b1);
          @(posedge clk); #1;
        end
        m_out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_count", obs_tag.size(), 20);
    for (int i = 0; i < 20; i++) check($sformatf("bp_tag%0d", i), obs_tag[i], i % 16);

    // Reset with two operands in flight.
    clear_obs();
    m_out_ready = 1'b0;
    send(16'h0100, 1'b0, 4'd13);
    send(16'h0003, 1'b1, 4'd14);
    m_in_valid = 1'b0;
    check("mid_before_valid", m_out_valid, 1);
    #1 m_rst = 1'b1;
    exp_q.delete();
    m_stall = 1'b0;
    #1;
    check("mid_rst_valid", m_out_valid, 0);
    check("mid_rst_count", m_out_count, 0);
    check("mid_rst_tag", m_out_tag, 0);
    #1 m_rst = 1'b0;
    m_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("mid_no_ghost", obs_cnt.size(), 0);
    clear_obs();
    send(16'h0040, 1'b0, 4'd15);
    idle(5);
    check("mid_next_n", obs_cnt.size(), 1);
    check("mid_next_count", obs_cnt[0], 9);
    check("mid_next_latency", obs_cyc[0] - acc_log[0], 2);
    check("m_queue_empty", exp_q.size(), 0);

    // Combinational WIDTH=2 instance: 2'b01 counts 1 in the same cycle.
    check("w2_p0_same_cycle_valid", first_valid_g0, 1);
    check("w2_p0_same_cycle_count", first_count_g0, 1);

    n = 0;
    while (sweeps_done < NCFG && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("sweeps_finished", sweeps_done, NCFG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
